// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the tone/PWM audio path.
//   tone_state_t   : tone computation FSM states (IDLE/DIV/MUL)
//   CLK_HZ_DEFAULT : default system clock frequency in Hz
//   NOTE_*         : note frequencies in Hz, C4..C6
//   DUTY_HALF      : 50% duty code for a 10-bit duty bus
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_MUL  = 2'd2
  } tone_state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  localparam int unsigned NOTE_C4 = 262;
  localparam int unsigned NOTE_D4 = 294;
  localparam int unsigned NOTE_E4 = 330;
  localparam int unsigned NOTE_F4 = 349;
  localparam int unsigned NOTE_G4 = 392;
  localparam int unsigned NOTE_A4 = 440;
  localparam int unsigned NOTE_B4 = 494;
  localparam int unsigned NOTE_C5 = 524;
  localparam int unsigned NOTE_D5 = 588;
  localparam int unsigned NOTE_E5 = 660;
  localparam int unsigned NOTE_F5 = 698;
  localparam int unsigned NOTE_G5 = 784;
  localparam int unsigned NOTE_A5 = 880;
  localparam int unsigned NOTE_B5 = 988;
  localparam int unsigned NOTE_C6 = 1048;

  localparam int unsigned DUTY_HALF = 512;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider computing CLK_HZ / i_divisor, one quotient
// bit per clock, exactly CNT_W clocks per division.
//   clk, rst    : clock, synchronous active-high reset
//   i_start     : load i_divisor and begin a division
//   i_divisor   : divisor (FREQ_W bits), sampled with i_start
//   o_done      : high during the final iteration; o_quotient is valid from
//                 the following cycle and holds until the next i_start
//   o_quotient  : result, saturated to all-ones on overflow, clamped to >= 2
module seq_divider
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned CNT_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [FREQ_W-1:0] i_divisor,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_quotient
);

  localparam int unsigned BIT_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int unsigned REM_W = FREQ_W + 1;
  localparam logic [63:0] DIVIDEND = 64'(CLK_HZ);
  // Dividend bits above the quotient width seed the remainder; if they alone
  // reach the divisor the quotient cannot fit in CNT_W bits.
  localparam logic [63:0] DIV_HI = DIVIDEND >> CNT_W;
  localparam logic [CNT_W-1:0] DIV_LO = DIVIDEND[CNT_W-1:0];

  logic              r_busy;
  logic              r_ovf;
  logic [BIT_W-1:0]  r_bit;
  logic [REM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_q;
  logic [FREQ_W-1:0] r_divisor;

  logic [REM_W-1:0]  w_shift;
  logic              w_ge;
  logic [REM_W-1:0]  w_rem_next;

  always_comb begin
    w_shift    = {r_rem[REM_W-2:0], DIV_LO[r_bit]};
    w_ge       = (w_shift >= {1'b0, r_divisor});
    w_rem_next = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
    o_done     = r_busy && (r_bit == '0);
    if (r_ovf) begin
      o_quotient = '1;
    end else if (r_q < CNT_W'(2)) begin
      o_quotient = CNT_W'(2);
    end else begin
      o_quotient = r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bit     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_ovf     <= (DIV_HI >= 64'(i_divisor));
      r_bit     <= BIT_W'(CNT_W - 1);
      r_rem     <= {1'b0, DIV_HI[FREQ_W-1:0]};
      r_q       <= '0;
      r_divisor <= i_divisor;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_q   <= {r_q[CNT_W-2:0], w_ge};
      if (r_bit == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_bit <= r_bit - BIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_pwm_synth.sv
// tone_pwm_synth: turns a note frequency (Hz) and duty code into a square/PWM
// waveform. Period = CLK_HZ / freq (sequential divider), high time =
// (period * duty) >> DUTY_W (sequential shift-add). New settings are adopted
// only at a period boundary (or immediately when muted).
//   clk, rst      : clock, synchronous active-high reset
//   freq_i        : tone frequency in Hz, 0 = mute
//   duty_i        : duty code, fraction = duty_i / 2^DUTY_W
//   freq_valid_i  : load request, samples freq_i and duty_i
//   busy_o        : divide or multiply in progress
//   pwm_o         : audio output
//   period_o      : active period in clocks, 0 when muted
// Optional build macro TONE_AUTO_RELOAD_EN: when defined, any change of
// freq_i/duty_i versus the last accepted request self-issues a load.
module tone_pwm_synth
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned DUTY_W = 10,
  parameter int unsigned CNT_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              freq_valid_i,
  output logic              busy_o,
  output logic              pwm_o,
  output logic [CNT_W-1:0]  period_o
);

  localparam int unsigned ACC_W  = CNT_W + DUTY_W;
  localparam int unsigned DBIT_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

  tone_state_t        r_state;
  logic               r_busy;
  logic [DUTY_W-1:0]  r_duty;
  logic [DBIT_W-1:0]  r_dbit;
  logic [ACC_W-1:0]   r_acc;
  logic               r_pending;
  logic [CNT_W-1:0]   r_pend_period;
  logic [CNT_W-1:0]   r_pend_high;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pwm;

  logic               w_req;
  logic               w_accept;
  logic               w_div_start;
  logic               w_div_done;
  logic [CNT_W-1:0]   w_quot;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_wrap;
  logic               w_adopt;

`ifdef TONE_AUTO_RELOAD_EN
  logic [FREQ_W-1:0] r_last_freq;
  logic [DUTY_W-1:0] r_last_duty;

  always_comb begin
    w_req = freq_valid_i || (freq_i != r_last_freq) || (duty_i != r_last_duty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_freq <= '0;
      r_last_duty <= '0;
    end else if (w_accept) begin
      r_last_freq <= freq_i;
      r_last_duty <= duty_i;
    end
  end
`else
  always_comb begin
    w_req = freq_valid_i;
  end
`endif

  seq_divider #(
    .CLK_HZ (CLK_HZ),
    .FREQ_W (FREQ_W),
    .CNT_W  (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_divisor  (freq_i),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

  always_comb begin
    w_accept    = (r_state == ST_IDLE) && w_req;
    w_div_start = w_accept && (freq_i != '0);
    // MSB-first shift-add: after DUTY_W steps r_acc = period * duty.
    w_acc_next  = {r_acc[ACC_W-2:0], 1'b0}
                + (r_duty[r_dbit] ? {{DUTY_W{1'b0}}, w_quot} : '0);
    w_wrap      = (r_period != '0) && (r_cnt == r_period - CNT_W'(1));
    w_adopt     = r_pending && ((r_period == '0) || w_wrap);
  end

  // Run counter and compute FSM share r_pending: a result finishing in the
  // same cycle as an adoption overrides the pending slot (later NBA wins)
  // while the older pending values are the ones adopted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_duty        <= '0;
      r_dbit        <= '0;
      r_acc         <= '0;
      r_pending     <= 1'b0;
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_period      <= '0;
      r_high        <= '0;
      r_cnt         <= '0;
      r_pwm         <= 1'b0;
    end else begin
      if (w_adopt) begin
        r_period  <= r_pend_period;
        r_high    <= r_pend_high;
        r_cnt     <= '0;
        r_pending <= 1'b0;
      end else if ((r_period == '0) || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_pwm <= (r_cnt < r_high);

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_duty <= duty_i;
            if (freq_i == '0) begin
              r_pending     <= 1'b1;
              r_pend_period <= '0;
              r_pend_high   <= '0;
            end else begin
              r_state <= ST_DIV;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_state <= ST_MUL;
            r_dbit  <= DBIT_W'(DUTY_W - 1);
            r_acc   <= '0;
          end
        end
        ST_MUL: begin
          r_acc <= w_acc_next;
          if (r_dbit == '0) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_pending     <= 1'b1;
            r_pend_period <= w_quot;
            r_pend_high   <= w_acc_next[ACC_W-1:DUTY_W];
          end else begin
            r_dbit <= r_dbit - DBIT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign pwm_o    = r_pwm;
  assign period_o = r_period;

endmodule

// File: tb/tb_tone_pwm_synth.sv
// Directed bench for tone_pwm_synth. u_dut_a runs at the default 100 MHz
// clock for latency, period values and extremes; u_dut_s uses a 1 MHz CLK_HZ
// so whole PWM periods (262 Hz -> 3816, 440 Hz -> 2272) fit in a short run.
module tb_tone_pwm_synth;
  import audio_pkg::*;

  localparam int unsigned FREQ_W = 32;
  localparam int unsigned DUTY_W = 10;
  localparam int unsigned CNT_W  = 27;
  localparam int LIM = 400000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [FREQ_W-1:0] freq_a, freq_s;
  logic [DUTY_W-1:0] duty_a, duty_s;
  logic fv_a, fv_s;
  logic busy_a, pwm_a, busy_s, pwm_s;
  logic [CNT_W-1:0] period_a, period_s;

  int n_tests = 0;
  int n_fail  = 0;

  tone_pwm_synth #(.CLK_HZ(100_000_000), .FREQ_W(FREQ_W), .DUTY_W(DUTY_W), .CNT_W(CNT_W)) u_dut_a (
    .clk(clk), .rst(rst), .freq_i(freq_a), .duty_i(duty_a), .freq_valid_i(fv_a),
    .busy_o(busy_a), .pwm_o(pwm_a), .period_o(period_a));

  tone_pwm_synth #(.CLK_HZ(1_000_000), .FREQ_W(FREQ_W), .DUTY_W(DUTY_W), .CNT_W(CNT_W)) u_dut_s (
    .clk(clk), .rst(rst), .freq_i(freq_s), .duty_i(duty_s), .freq_valid_i(fv_s),
    .busy_o(busy_s), .pwm_o(pwm_s), .period_o(period_s));

  always #5 clk = ~clk;

  function automatic logic pwm_of(input bit sel);
    return sel ? pwm_s : pwm_a;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_s : busy_a;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    freq_a = '0; duty_a = '0; fv_a = 1'b0;
    freq_s = '0; duty_s = '0; fv_s = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Returns at the first sample of the cycle after acceptance.
  task automatic load(input bit sel, input int unsigned f, input int unsigned d);
    if (sel) begin freq_s = f; duty_s = DUTY_W'(d); fv_s = 1'b1; end
    else     begin freq_a = f; duty_a = DUTY_W'(d); fv_a = 1'b1; end
    tick();
    fv_a = 1'b0; fv_s = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, output int nb);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy_of(sel) !== 1'b1) break;
      nb++;
      tick();
    end
  endtask

  task automatic align(input bit sel);
    for (int i = 0; i < LIM; i++) begin
      if (pwm_of(sel) === 1'b0) break;
      tick();
    end
    for (int i = 0; i < LIM; i++) begin
      if (pwm_of(sel) === 1'b1) break;
      tick();
    end
  endtask

  // Starts on the first high sample of a period, ends on the next one.
  task automatic measure(input bit sel, output int hi, output int lo);
    hi = 0; lo = 0;
    while (pwm_of(sel) === 1'b1 && hi < LIM) begin hi++; tick(); end
    while (pwm_of(sel) === 1'b0 && lo < LIM) begin lo++; tick(); end
  endtask

  task automatic test_reset();
    int bad;
    freq_a = '0; duty_a = '0; fv_a = 1'b0;
    freq_s = '0; duty_s = '0; fv_s = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_tests++; if (pwm_a !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_a); end
    n_tests++; if (period_a !== '0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period_a); end
    n_tests++; if ({busy_s, pwm_s, period_s} !== '0) begin n_fail++; $display("FAIL reset_dut_s: got %0h expected 0", {busy_s, pwm_s, period_s}); end
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      tick();
      if (busy_a !== 1'b0 || pwm_a !== 1'b0 || period_a !== '0 ||
          busy_s !== 1'b0 || pwm_s !== 1'b0 || period_s !== '0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL idle_1000: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_latency_262();
    int nb;
    load(1'b0, NOTE_C4, DUTY_HALF);
    wait_idle(1'b0, nb);
    n_tests++; if (nb !== 37) begin n_fail++; $display("FAIL busy_cycles: got %0d expected 37", nb); end
    n_tests++; if (period_a !== '0) begin n_fail++; $display("FAIL period_before_adopt: got %0d expected 0", period_a); end
    tick();
    n_tests++; if (period_a !== 27'd381679) begin n_fail++; $display("FAIL period_262: got %0d expected 381679", period_a); end
    repeat (2) tick();
    n_tests++; if (pwm_a !== 1'b1) begin n_fail++; $display("FAIL pwm_262_start: got %b expected 1", pwm_a); end
  endtask

  task automatic test_reset_abort();
    load(1'b0, NOTE_A4, DUTY_HALF);
    repeat (9) tick();
    do_reset();
    n_tests++; if (busy_a !== 1'b0 || period_a !== '0) begin n_fail++; $display("FAIL abort_state: got busy=%b period=%0d expected busy=0 period=0", busy_a, period_a); end
    repeat (60) tick();
    n_tests++; if ({busy_a, pwm_a, period_a} !== '0) begin n_fail++; $display("FAIL abort_discard: got busy=%b pwm=%b period=%0d expected all 0", busy_a, pwm_a, period_a); end
  endtask

  task automatic test_play_262();
    int nb, hi, lo;
    load(1'b1, NOTE_C4, DUTY_HALF);
    wait_idle(1'b1, nb);
    tick();
    n_tests++; if (period_s !== 27'd3816) begin n_fail++; $display("FAIL play_period: got %0d expected 3816", period_s); end
    align(1'b1);
    for (int p = 0; p < 2; p++) begin
      measure(1'b1, hi, lo);
      n_tests++; if (hi !== 1908) begin n_fail++; $display("FAIL play_high%0d: got %0d expected 1908", p, hi); end
      n_tests++; if (lo !== 1908) begin n_fail++; $display("FAIL play_low%0d: got %0d expected 1908", p, lo); end
    end
  endtask

  task automatic test_glitch_free();
    int hi, lo;
    hi = 0;
    while (pwm_s === 1'b1 && hi < LIM) begin
      if (hi == 500) begin freq_s = NOTE_A4; duty_s = DUTY_W'(DUTY_HALF); fv_s = 1'b1; end
      else fv_s = 1'b0;
      hi++;
      tick();
    end
    fv_s = 1'b0;
    n_tests++; if (hi !== 1908) begin n_fail++; $display("FAIL old_high: got %0d expected 1908", hi); end
    n_tests++; if (period_s !== 27'd3816) begin n_fail++; $display("FAIL old_period_kept: got %0d expected 3816", period_s); end
    lo = 0;
    while (pwm_s === 1'b0 && lo < LIM) begin lo++; tick(); end
    n_tests++; if (lo !== 1908) begin n_fail++; $display("FAIL old_low: got %0d expected 1908", lo); end
    measure(1'b1, hi, lo);
    n_tests++; if (hi !== 1136 || lo !== 1136) begin n_fail++; $display("FAIL new_440: got hi=%0d lo=%0d expected 1136/1136", hi, lo); end
    n_tests++; if (period_s !== 27'd2272) begin n_fail++; $display("FAIL new_period: got %0d expected 2272", period_s); end
  endtask

  task automatic test_busy_ignore();
    int nb, bad;
    load(1'b1, NOTE_A4, DUTY_HALF);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy_s !== 1'b1) break;
      nb++;
      if (nb == 10) begin freq_s = NOTE_B4; fv_s = 1'b1; end
      else begin freq_s = NOTE_A4; fv_s = 1'b0; end
      tick();
    end
    n_tests++; if (nb !== 37) begin n_fail++; $display("FAIL ignore_busy_len: got %0d expected 37", nb); end
    bad = 0;
    repeat (100) begin tick(); if (busy_s !== 1'b0) bad++; end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL ignore_no_reload: got %0d busy cycles expected 0", bad); end
    repeat (2400) tick();
    n_tests++; if (period_s !== 27'd2272) begin n_fail++; $display("FAIL ignore_period: got %0d expected 2272", period_s); end
  endtask

  task automatic test_mute();
    bit found;
    int bad;
    load(1'b1, 0, DUTY_HALF);
    n_tests++; if (busy_s !== 1'b0 || period_s !== 27'd2272) begin n_fail++; $display("FAIL mute_deferred: got busy=%b period=%0d expected busy=0 period=2272", busy_s, period_s); end
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (period_s === '0) begin found = 1'b1; break; end
      tick();
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL mute_adopt: got period=%0d expected 0 within 3000 cycles", period_s); end
    bad = 0;
    repeat (200) begin tick(); if (pwm_s !== 1'b0 || period_s !== '0) bad++; end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mute_silent: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_extremes();
    int nb, hi, lo, cnt;
    do_reset();
    load(1'b0, 1, DUTY_HALF);
    wait_idle(1'b0, nb); tick();
    n_tests++; if (period_a !== 27'd100000000) begin n_fail++; $display("FAIL freq_1hz: got %0d expected 100000000", period_a); end
    do_reset();
    load(1'b0, 200_000_000, DUTY_HALF);
    wait_idle(1'b0, nb); tick();
    n_tests++; if (period_a !== 27'd2) begin n_fail++; $display("FAIL freq_clamp: got %0d expected 2", period_a); end
    tick();
    cnt = 0;
    repeat (10) begin tick(); if (pwm_a === 1'b1) cnt++; end
    n_tests++; if (cnt !== 5) begin n_fail++; $display("FAIL period2_toggle: got %0d highs expected 5", cnt); end
    do_reset();
    load(1'b0, 97656, 0);
    wait_idle(1'b0, nb); tick();
    n_tests++; if (period_a !== 27'd1024) begin n_fail++; $display("FAIL period_1024: got %0d expected 1024", period_a); end
    cnt = 0;
    repeat (2100) begin tick(); if (pwm_a !== 1'b0) cnt++; end
    n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL duty_zero: got %0d non-low cycles expected 0", cnt); end
    do_reset();
    load(1'b0, 97656, 1023);
    wait_idle(1'b0, nb); tick();
    align(1'b0);
    measure(1'b0, hi, lo);
    n_tests++; if (hi !== 1023 || lo !== 1) begin n_fail++; $display("FAIL duty_max: got hi=%0d lo=%0d expected 1023/1", hi, lo); end
  endtask

  task automatic test_auto_reload();
    int nb;
    bit found;
    do_reset();
    freq_a = NOTE_D4; duty_a = DUTY_W'(DUTY_HALF);
    tick();
`ifdef TONE_AUTO_RELOAD_EN
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL auto_start: got busy=%b expected 1", busy_a); end
    wait_idle(1'b0, nb); tick();
    n_tests++; if (period_a !== 27'd340136) begin n_fail++; $display("FAIL auto_period: got %0d expected 340136", period_a); end
`else
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL noauto_start: got busy=%b expected 0", busy_a); end
    repeat (60) tick();
    n_tests++; if (period_a !== '0) begin n_fail++; $display("FAIL noauto_period: got %0d expected 0", period_a); end
`endif
    do_reset();
    load(1'b1, NOTE_C4, DUTY_HALF);
    wait_idle(1'b1, nb);
    repeat (2) tick();
    freq_s = NOTE_D4;
    tick();
`ifdef TONE_AUTO_RELOAD_EN
    n_tests++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL auto_s_start: got busy=%b expected 1", busy_s); end
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (period_s === 27'd3401) begin found = 1'b1; break; end
      tick();
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL auto_s_period: got %0d expected 3401", period_s); end
`else
    found = 1'b0;
    n_tests++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL noauto_s_start: got busy=%b expected 0", busy_s); end
    repeat (4000) tick();
    n_tests++; if (period_s !== 27'd3816) begin n_fail++; $display("FAIL noauto_s_period: got %0d expected 3816", period_s); end
`endif
  endtask

  initial begin
    test_reset();
    test_latency_262();
    test_reset_abort();
    test_play_262();
    test_glitch_free();
    test_busy_ignore();
    test_mute();
    test_extremes();
    test_auto_reload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_pwm_synth.md
Name: tone_pwm_synth

Overview:
- Downstream audio stage that turns a note frequency in Hz and a duty code into a square/PWM waveform on the speaker pmod pin.
- Computes the tone period as CLK_HZ / freq with a sequential divider, then the high time with a sequential shift-add multiply.
- Applies new settings only at a period boundary, so tone changes are glitch-free.
- Sits between the note sequencer/keyboard control logic and the board audio pin.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- FREQ_W, 32, width of freq_i.
- DUTY_W, 10, width of duty_i; duty fraction = duty_i / 2^DUTY_W.
- CNT_W, 27, width of the period counter and quotient; 2^27 > 100e6, so 1 Hz fits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- freq_i  in  FREQ_W  requested tone frequency in Hz; 0 = mute.
- duty_i  in  DUTY_W  requested duty code.
- freq_valid_i  in  1  load request; freq_i and duty_i are sampled in the same cycle.
- busy_o  out  1  high while the divide or multiply is running.
- pwm_o  out  1  audio output.
- period_o  out  CNT_W  active period in clocks; 0 when muted.

Behaviour:
- Reset: pwm_o=0, busy_o=0, period_o=0, FSM=IDLE, pending=0, muted. Reset asserted mid-DIV or mid-MUL aborts the computation and discards any pending result.
- FSM states: IDLE, DIV, MUL.
- IDLE:
  - freq_valid_i=1 latches freq_i and duty_i.
  - freq_i=0: set pending with period=0, high=0; stay in IDLE.
  - Otherwise go to DIV.
- DIV: restoring divide of CLK_HZ by freq, one quotient bit per cycle, exactly CNT_W cycles.
  - Quotient overflowing CNT_W bits saturates to 2^CNT_W-1.
  - Quotient <2, including freq > CLK_HZ, clamps to 2.
- MUL: high = (period * duty) >> DUTY_W, one duty bit per cycle, exactly DUTY_W cycles. Result is floored.
- After MUL: pending=1, return to IDLE.
- Latency: request accepted in cycle N gives busy_o=1 for cycles N+1 .. N+CNT_W+DUTY_W, and pending is set in that same last cycle.
- freq_valid_i while busy_o=1 is ignored.
- A new request accepted while pending=1 but busy_o=0 overwrites the pending result.
- Run counter cnt: counts 0..period-1 and wraps.
  - pwm_o = (cnt < high), registered, so pwm_o lags cnt by 1 cycle.
  - When muted (period=0), cnt holds at 0 and pwm_o=0.
- Adoption of pending values:
  - At wrap (cnt==period-1) with pending=1: load the new period/high, clear pending, cnt goes to 0.
  - If currently muted, pending values are adopted on the next cycle without waiting for a wrap.
  - A pending mute is also adopted only at the wrap.
- Duty extremes: duty=0 gives constant low. duty=2^DUTY_W-1 gives low for at least 1 cycle per period.
- period_o updates in the same cycle the new period is adopted.

Optional Feature:
- Macro TONE_AUTO_RELOAD_EN.
- Defined: the block keeps the last requested freq/duty. When idle and freq_i or duty_i differs from them, it self-issues a load request, so a continuously driven freq bus needs no freq_valid_i. freq_valid_i is still honoured.
- Undefined: only freq_valid_i starts a load, and the compare registers are not built.

Decomposition:
- Package audio_pkg:
  - FSM state enum (IDLE/DIV/MUL).
  - Default CLK_HZ.
  - Note frequency constants C4..C6 (262, 294, 330, 349, 392, 440, 494 and their octave multiples).
  - DUTY_HALF = 512.
- Sub-module seq_divider: start/done handshake, CNT_W-cycle restoring divider with saturation. Instantiated once. The multiply stays inline.

Test Plan:
- Reset then idle: no request for 1000 cycles -> pwm_o=0, period_o=0, busy_o=0 throughout.
- freq_i=262, duty_i=512, pulse freq_valid_i -> busy_o high exactly 37 cycles; period_o=381679; pwm_o high 190839 cycles, low 190840, repeating.
- While playing 262 Hz, load 440/512 mid-period -> current period completes unchanged; new period 227272, high 113636 from the wrap onward; no runt pulse.
- freq_valid_i pulsed again at the 10th busy cycle with freq_i=494 -> ignored; result stays 440 Hz. freq_i=0 load -> pwm_o=0 and period_o=0 after the current period ends.
- Extremes: freq_i=1 -> period_o=100_000_000; freq_i=200_000_000 -> period_o=2; duty_i=0 -> pwm_o constant 0; duty_i=1023 with period 1024 -> high 1023, low 1.
- TONE_AUTO_RELOAD_EN: change freq_i 262->294 with no freq_valid_i -> load starts within 1 cycle and period becomes 340136. With the macro undefined, the same stimulus causes no change.
